// File: rtl/regfile_2r1w.sv
// regfile_2r1w: register file with two combinational read ports, one write port,
// per-entry pending scoreboard and a registered pending-entry count.
`default_nettype none

module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_D   = 32,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic              ra_busy,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  output logic              rb_busy,
  input  logic              we_,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              lock_,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] data_q [DATA_D];
  logic [DATA_W-1:0] data_d [DATA_D];
  logic [DATA_D-1:0] pend_q;
  logic [DATA_D-1:0] pend_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  logic              wr_en;
  logic              lk_en;
  logic              pend_rise;
  logic              pend_fall;
  logic [DATA_W:0]   ra_word;
  logic [DATA_W:0]   rb_word;

  // Widened compare so DATA_D == 2**ADDR_W does not overflow the address width.
  function automatic logic addr_valid(input logic [ADDR_W-1:0] a);
    logic in_range;
    in_range = ({1'b0, a} < CNT_W'(DATA_D));
    return in_range && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Returns {busy, data} for one read port; the write bypass wins over storage.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    logic              b;
    d = '0;
    b = 1'b0;
    for (int i = 0; i < DATA_D; i++) begin
      if (a == ADDR_W'(i)) begin
        d = data_q[i];
        b = pend_q[i];
      end
    end
    if (!addr_valid(a)) begin
      d = '0;
      b = 1'b0;
    end else if (!we_ && (waddr == a)) begin
      d = wdata;
      b = 1'b0;
    end
    if (!reset_) begin
      d = '0;
      b = 1'b0;
    end
    return {b, d};
  endfunction

  always_comb begin
    ra_word = read_port(ra_addr);
    rb_word = read_port(rb_addr);
  end

  assign ra_data  = ra_word[DATA_W-1:0];
  assign ra_busy  = ra_word[DATA_W];
  assign rb_data  = rb_word[DATA_W-1:0];
  assign rb_busy  = rb_word[DATA_W];
  assign pend_cnt = cnt_q;

  always_comb begin
    data_d = data_q;
    pend_d = pend_q;
    wr_en  = !we_ && addr_valid(waddr);
    lk_en  = !lock_ && addr_valid(lock_addr);

    for (int i = 0; i < DATA_D; i++) begin
      if (wr_en && (waddr == ADDR_W'(i))) begin
        data_d[i] = wdata;
        pend_d[i] = 1'b0;
      end
    end
    // Lock is applied after the write so a same-entry lock leaves the bit set.
    for (int i = 0; i < DATA_D; i++) begin
      if (lk_en && (lock_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end
    end

    pend_rise = |(pend_d & ~pend_q);
    pend_fall = |(~pend_d & pend_q);

    cnt_d = cnt_q;
    if (pend_rise && !pend_fall && (cnt_q != CNT_W'(DATA_D))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pend_fall && !pend_rise && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      data_q <= '{default: '0};
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// tb_regfile_2r1w: directed checks of a default register file and a
// ZERO_REG=1, DATA_D=24 instance driven by the same stimulus.
`default_nettype none

module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset_;
  logic [4:0]  ra_addr, rb_addr, waddr, lock_addr;
  logic [31:0] wdata;
  logic        we_, lock_;

  logic [31:0] ra_data0, rb_data0, ra_data1, rb_data1;
  logic        ra_busy0, rb_busy0, ra_busy1, rb_busy1;
  logic [5:0]  pend_cnt0, pend_cnt1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .DATA_D(32), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset_(reset_),
    .ra_addr(ra_addr), .ra_data(ra_data0), .ra_busy(ra_busy0),
    .rb_addr(rb_addr), .rb_data(rb_data0), .rb_busy(rb_busy0),
    .we_(we_), .waddr(waddr), .wdata(wdata),
    .lock_(lock_), .lock_addr(lock_addr), .pend_cnt(pend_cnt0)
  );

  regfile_2r1w #(.DATA_W(32), .ADDR_W(5), .DATA_D(24), .ZERO_REG(1)) dut1 (
    .clk(clk), .reset_(reset_),
    .ra_addr(ra_addr), .ra_data(ra_data1), .ra_busy(ra_busy1),
    .rb_addr(rb_addr), .rb_data(rb_data1), .rb_busy(rb_busy1),
    .we_(we_), .waddr(waddr), .wdata(wdata),
    .lock_(lock_), .lock_addr(lock_addr), .pend_cnt(pend_cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Inputs change on the falling edge; combinational reads are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
    we_   = 1'b1;
    lock_ = 1'b1;
  endtask

  initial begin
    // Reset held with an active write and lock on entry 5.
    reset_ = 1'b0; we_ = 1'b0; waddr = 5'd5; wdata = 32'hDEADBEEF;
    lock_ = 1'b0; lock_addr = 5'd5; ra_addr = 5'd5; rb_addr = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ra_data", ra_data0, 32'h0);
    check("rst_rb_data", rb_data0, 32'h0);
    check("rst_ra_busy", {31'b0, ra_busy0}, 32'h0);
    check("rst_pend_cnt", {26'b0, pend_cnt0}, 32'h0);
    next_cycle();
    reset_ = 1'b1;
    @(negedge clk); #1;
    check("post_rst_e5", ra_data0, 32'h0);

    // Write with bypass on both ports.
    next_cycle();
    we_ = 1'b0; waddr = 5'd7; wdata = 32'h12345678; ra_addr = 5'd7; rb_addr = 5'd7;
    #1;
    check("byp_ra", ra_data0, 32'h12345678);
    check("byp_rb", rb_data0, 32'h12345678);
    next_cycle(); #1;
    check("stored_e7", ra_data0, 32'h12345678);

    // Lock 3, then clear it by a write.
    lock_ = 1'b0; lock_addr = 5'd3; ra_addr = 5'd3; #1;
    check("lock_cycle_busy", {31'b0, ra_busy0}, 32'h0);
    next_cycle(); #1;
    check("lock3_busy", {31'b0, ra_busy0}, 32'h1);
    check("lock3_cnt", {26'b0, pend_cnt0}, 32'h1);
    we_ = 1'b0; waddr = 5'd3; wdata = 32'hA5A5A5A5; #1;
    check("wr3_byp_busy", {31'b0, ra_busy0}, 32'h0);
    check("wr3_byp_data", ra_data0, 32'hA5A5A5A5);
    next_cycle(); #1;
    check("wr3_cnt", {26'b0, pend_cnt0}, 32'h0);
    check("wr3_busy", {31'b0, ra_busy0}, 32'h0);

    // Lock 9, then lock and write 9 together while pending.
    lock_ = 1'b0; lock_addr = 5'd9;
    next_cycle();
    we_ = 1'b0; waddr = 5'd9; wdata = 32'h11112222; lock_ = 1'b0; lock_addr = 5'd9;
    ra_addr = 5'd9; #1;
    check("lw9_byp_data", ra_data0, 32'h11112222);
    check("lw9_byp_busy", {31'b0, ra_busy0}, 32'h0);
    next_cycle(); #1;
    check("lw9_data", ra_data0, 32'h11112222);
    check("lw9_busy", {31'b0, ra_busy0}, 32'h1);
    check("lw9_cnt", {26'b0, pend_cnt0}, 32'h1);
    // Lock 4 while writing pending 9.
    we_ = 1'b0; waddr = 5'd9; wdata = 32'h33334444; lock_ = 1'b0; lock_addr = 5'd4;
    ra_addr = 5'd4; rb_addr = 5'd9;
    next_cycle(); #1;
    check("l4w9_cnt", {26'b0, pend_cnt0}, 32'h1);
    check("l4w9_busy4", {31'b0, ra_busy0}, 32'h1);
    check("l4w9_busy9", {31'b0, rb_busy0}, 32'h0);
    check("l4w9_data9", rb_data0, 32'h33334444);
    we_ = 1'b0; waddr = 5'd4; wdata = 32'h0;
    next_cycle(); #1;
    check("clr4_cnt0", {26'b0, pend_cnt0}, 32'h0);
    check("clr4_cnt1", {26'b0, pend_cnt1}, 32'h0);

    // Entry 0 is hard-wired on dut1 but ordinary on dut0.
    we_ = 1'b0; waddr = 5'd0; wdata = 32'hFFFFFFFF; lock_ = 1'b0; lock_addr = 5'd0;
    ra_addr = 5'd0; rb_addr = 5'd0; #1;
    check("z0_nobyp_data", ra_data1, 32'h0);
    check("z0_nobyp_busy", {31'b0, ra_busy1}, 32'h0);
    check("d0_byp_data", ra_data0, 32'hFFFFFFFF);
    next_cycle(); #1;
    check("z0_data", rb_data1, 32'h0);
    check("z0_busy", {31'b0, rb_busy1}, 32'h0);
    check("z0_cnt", {26'b0, pend_cnt1}, 32'h0);
    check("d0_busy", {31'b0, ra_busy0}, 32'h1);
    check("d0_cnt", {26'b0, pend_cnt0}, 32'h1);

    // Address 26 lies outside DATA_D=24.
    we_ = 1'b0; waddr = 5'd26; wdata = 32'hFFFFFFFF; lock_ = 1'b0; lock_addr = 5'd26;
    ra_addr = 5'd26; #1;
    check("oor_nobyp", ra_data1, 32'h0);
    next_cycle(); #1;
    check("oor_data", ra_data1, 32'h0);
    check("oor_busy", {31'b0, ra_busy1}, 32'h0);
    check("oor_cnt", {26'b0, pend_cnt1}, 32'h0);
    check("d26_cnt", {26'b0, pend_cnt0}, 32'h2);

    // Asynchronous reset pulse away from any clock edge.
    #2 reset_ = 1'b0; #1;
    check("arst_cnt", {26'b0, pend_cnt0}, 32'h0);
    check("arst_read", ra_data0, 32'h0);
    next_cycle();
    reset_ = 1'b1;

    // Fill: lock every address once.
    for (int i = 0; i < 32; i++) begin
      lock_ = 1'b0; lock_addr = 5'(i);
      next_cycle();
    end
    #1;
    check("fill_cnt0", {26'b0, pend_cnt0}, 32'd32);
    check("fill_cnt1", {26'b0, pend_cnt1}, 32'd23);
    lock_ = 1'b0; lock_addr = 5'd1;
    next_cycle(); #1;
    check("relock_cnt0", {26'b0, pend_cnt0}, 32'd32);
    check("relock_cnt1", {26'b0, pend_cnt1}, 32'd23);
    ra_addr = 5'd7; rb_addr = 5'd9; #1;
    check("fill_busy7", {31'b0, ra_busy0}, 32'h1);

    // Reset mid-sequence while a lock is being requested.
    lock_ = 1'b0; lock_addr = 5'd2;
    #2 reset_ = 1'b0; #1;
    check("mid_rst_cnt0", {26'b0, pend_cnt0}, 32'h0);
    check("mid_rst_cnt1", {26'b0, pend_cnt1}, 32'h0);
    check("mid_rst_busy", {31'b0, ra_busy0}, 32'h0);
    next_cycle();
    reset_ = 1'b1;
    @(negedge clk); #1;
    check("after_rst_e9", rb_data0, 32'h0);
    check("after_rst_busy9", {31'b0, rb_busy0}, 32'h0);
    check("after_rst_cnt", {26'b0, pend_cnt0}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
